rv32i_fetch_ctrl: RTL and testbench
===================================

// Module: rv32i_fetch_ctrl
// PURPOSE
//  Multi-cycle fetch/sequence controller for the RV32I core. Owns the PC, fetches
//  one instruction per step over a req/ack instruction-memory port, and holds it
//  in the instruction register. instr_o drives the immediate generator and decoder.
//  Waits for the execute stage to retire, then loads the next PC. Traps on fault.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC loaded on reset and on trap_clr_i
//  TIMEOUT_CYC   16             max cycles in REQ without ack/err before a timeout trap
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_ni         in   1   asynchronous reset, active low
//  en_i           in   1   run enable
//  imem_req_o     out  1   fetch request, held until ack or err
//  imem_addr_o    out  32  fetch address (= pc_o while imem_req_o = 1)
//  imem_ack_i     in   1   fetch complete; imem_rdata_i is valid this cycle
//  imem_err_i     in   1   bus error for the current fetch
//  imem_rdata_i   in   32  fetched instruction word
//  instr_o        out  32  instruction register, to the imm generator and decoder
//  instr_valid_o  out  1   instr_o/pc_o are valid for execute
//  pc_o           out  32  PC of the instruction in instr_o
//  exec_done_i    in   1   execute retires instr_o this cycle
//  next_pc_i      in   32  next PC, sampled when exec_done_i = 1
//  trap_o         out  1   sticky fault flag
//  trap_cause_o   out  2   00 misaligned PC, 01 bus error, 10 timeout, 11 reserved
//  trap_clr_i     in   1   clears the trap and restarts from RESET_PC
//  instret_o      out  32  retired-instruction counter
// BEHAVIOUR
//  - All outputs are registered. Reset (rst_ni = 0, async) sets: state IDLE,
//    pc_o = RESET_PC, instr_o = 32'h0000_0013 (NOP), instr_valid_o = 0,
//    imem_req_o = 0, trap_o = 0, trap_cause_o = 0, instret_o = 0, timeout counter = 0.
//  - States: IDLE, REQ, EXEC, TRAP. imem_req_o = 1 only in REQ.
//  - IDLE:
//    - en_i = 1 and pc_o[1:0] != 0 -> TRAP, cause 00; no request is issued.
//    - en_i = 1 and PC aligned -> REQ on the next cycle.
//  - REQ: imem_addr_o = pc_o. The timeout counter increments each cycle without a
//    response.
//    - err = 1 -> TRAP, cause 01. err wins over a same-cycle ack.
//    - ack = 1 (no err) -> latch instr_o <= imem_rdata_i, go to EXEC, clear the
//      counter. instr_valid_o rises in the cycle after ack (1-cycle latency).
//    - Counter reaches TIMEOUT_CYC - 1 with no ack/err -> TRAP, cause 10. An ack in
//      that same cycle wins.
//  - EXEC: instr_valid_o = 1 and instr_o is stable until exec_done_i.
//    - On exec_done_i: pc_o <= next_pc_i, instret_o += 1 (wraps 2^32-1 -> 0),
//      instr_valid_o <= 0.
//    - Then REQ if en_i = 1 and next_pc_i[1:0] == 0. If en_i = 1 and misaligned,
//      go to TRAP, cause 00. If en_i = 0, go to IDLE.
//  - en_i is sampled only in IDLE and at exec_done_i. A fetch in flight always
//    completes; deasserting en_i never aborts the bus.
//  - Bus inputs are ignored outside REQ. exec_done_i is ignored outside EXEC.
//  - TRAP: trap_o = 1 and trap_cause_o is held. imem_req_o = 0, instr_valid_o = 0.
//    trap_clr_i -> IDLE with pc_o = RESET_PC and trap_o = 0; instret_o is kept.
//  - trap_clr_i is ignored in every state other than TRAP.
//  - Reset asserted mid-fetch drops imem_req_o immediately (async).
// TESTING
//  1. Reset, en_i=1, ack with rdata 32'h0050_0093 two cycles after req ->
//     instr_o = 32'h0050_0093 and instr_valid_o = 1 the cycle after ack; pc_o = 0.
//  2. exec_done_i with next_pc_i = 32'h0000_0004 -> next req addr = 4, instret_o = 1.
//     Then next_pc_i = 32'h0000_0006 -> trap_o = 1, cause 00, no req issued.
//  3. imem_ack_i and imem_err_i both high in the same cycle -> trap_o = 1, cause 01,
//     and instr_o remains unchanged.
//  4. TIMEOUT_CYC = 4, no ack -> trap (cause 10) asserted after 4 req cycles. Rerun
//     with ack on the 4th cycle -> no trap.
//  5. en_i dropped mid-REQ -> the fetch completes and EXEC runs; after exec_done_i
//     the state is IDLE and imem_req_o = 0.
//  6. trap_clr_i in TRAP -> pc_o = RESET_PC, trap_o = 0, instret_o preserved.
//     Reset asserted during REQ -> imem_req_o = 0 asynchronously.

Source files
------------

// File: rtl/rv32i_fetch_ctrl.sv
// RV32I multi-cycle fetch/sequence controller: owns the PC, fetches one word per step
// over a req/ack port into the instruction register, waits for retire, traps on faults.
module rv32i_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic        imem_err_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  input  logic        exec_done_i,
  input  logic [31:0] next_pc_i,
  output logic        trap_o,
  output logic [1:0]  trap_cause_o,
  input  logic        trap_clr_i,
  output logic [31:0] instret_o
);

  localparam int          CW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b00;
  localparam logic [1:0] CAUSE_BUSERR   = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_EXEC, S_TRAP} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     instret_q, instret_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic            trap_q, trap_d;
  logic [1:0]      cause_q, cause_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          if (pc_q[1:0] != 2'b00) begin
            state_d = S_TRAP;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // priority: err over ack, ack over timeout
        if (imem_err_i) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUSERR;
          cnt_d   = '0;
        end else if (imem_ack_i) begin
          state_d = S_EXEC;
          instr_d = imem_rdata_i;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EXEC: begin
        if (exec_done_i) begin
          pc_d      = next_pc_i;
          instret_d = instret_q + 32'd1;
          if (!en_i) begin
            state_d = S_IDLE;
          end else if (next_pc_i[1:0] != 2'b00) begin
            state_d = S_TRAP;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_TRAP: begin
        if (trap_clr_i) begin
          state_d = S_IDLE;
          pc_d    = RESET_PC;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // status outputs are registered copies of the next-state decode
    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_EXEC);
    trap_d  = (state_d == S_TRAP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      instret_q <= '0;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      valid_q   <= valid_d;
      req_q     <= req_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign trap_o        = trap_q;
  assign trap_cause_o  = cause_q;
  assign instret_o     = instret_q;

endmodule

// File: tb/tb_rv32i_fetch_ctrl.sv
// Scoreboard bench for rv32i_fetch_ctrl: stimulus pushes expected request/valid/trap
// events; a negedge monitor pops and compares them as the DUT raises each output.
module tb_rv32i_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_i, imem_req_o, imem_ack_i, imem_err_i;
  logic [31:0] imem_addr_o, imem_rdata_i, instr_o, pc_o, next_pc_i, instret_o;
  logic        instr_valid_o, exec_done_i, trap_o, trap_clr_i;
  logic [1:0]  trap_cause_o;

  int checks = 0;
  int errors = 0;

  localparam int K_REQ = 0, K_VALID = 1, K_TRAP = 2;
  typedef struct {
    int          kind;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] cnt;
    logic [1:0]  cause;
  } exp_t;
  exp_t sb[$];

  rv32i_fetch_ctrl #(.RESET_PC(32'h0), .TIMEOUT_CYC(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_err_i(imem_err_i), .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .pc_o(pc_o),
    .exec_done_i(exec_done_i), .next_pc_i(next_pc_i),
    .trap_o(trap_o), .trap_cause_o(trap_cause_o), .trap_clr_i(trap_clr_i),
    .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  function automatic void push(input int k, input logic [31:0] pc, input logic [31:0] ins,
                               input logic [31:0] n, input logic [1:0] c);
    exp_t e;
    e.kind = k; e.pc = pc; e.instr = ins; e.cnt = n; e.cause = c;
    sb.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: compare each rising output event against the scoreboard head
  task automatic mon_evt(input int k);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d pc=%h", k, pc_o);
    end else begin
      e = sb.pop_front();
      if (e.kind != k) begin
        errors++;
        $display("FAIL event_kind: got %0d expected %0d", k, e.kind);
      end else if (k == K_REQ && imem_addr_o !== e.pc) begin
        errors++;
        $display("FAIL req_addr: got %h expected %h", imem_addr_o, e.pc);
      end else if (k == K_VALID && (pc_o !== e.pc || instr_o !== e.instr || instret_o !== e.cnt)) begin
        errors++;
        $display("FAIL valid_fields: got pc=%h instr=%h instret=%0d expected pc=%h instr=%h instret=%0d",
                 pc_o, instr_o, instret_o, e.pc, e.instr, e.cnt);
      end else if (k == K_TRAP && (trap_cause_o !== e.cause || pc_o !== e.pc)) begin
        errors++;
        $display("FAIL trap_fields: got cause=%b pc=%h expected cause=%b pc=%h",
                 trap_cause_o, pc_o, e.cause, e.pc);
      end
    end
  endtask

  logic req_p = 1'b0, val_p = 1'b0, trap_p = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (imem_req_o && !req_p)    mon_evt(K_REQ);
      if (instr_valid_o && !val_p) mon_evt(K_VALID);
      if (trap_o && !trap_p)       mon_evt(K_TRAP);
    end
    req_p  <= imem_req_o;
    val_p  <= instr_valid_o;
    trap_p <= trap_o;
  end

  task automatic wait_req();
    for (int i = 0; i < 20 && !imem_req_o; i++) @(negedge clk);
    if (!imem_req_o) begin
      checks++;
      errors++;
      $display("FAIL wait_req: got req=0 expected req=1 within 20 cycles");
    end
  endtask

  // respond in the nth REQ cycle (1 = first)
  task automatic fetch(input logic [31:0] data, input int nth, input bit err, input bit ack);
    wait_req();
    repeat (nth - 1) @(negedge clk);
    imem_ack_i = ack; imem_err_i = err; imem_rdata_i = data;
    @(negedge clk);
    imem_ack_i = 1'b0; imem_err_i = 1'b0; imem_rdata_i = 32'h0;
  endtask

  task automatic pulse_done(input logic [31:0] npc);
    exec_done_i = 1'b1; next_pc_i = npc;
    @(negedge clk);
    exec_done_i = 1'b0;
  endtask

  task automatic pulse_clr();
    trap_clr_i = 1'b1;
    @(negedge clk);
    trap_clr_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; en_i = 1'b0; imem_ack_i = 1'b0; imem_err_i = 1'b0; imem_rdata_i = 32'h0;
    exec_done_i = 1'b0; next_pc_i = 32'h0; trap_clr_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_instr", instr_o, 32'h0000_0013);
    chk("rst_flags", {28'h0, instr_valid_o, imem_req_o, trap_o, 1'b0}, 32'h0);
    chk("rst_cause", {30'h0, trap_cause_o}, 32'h0);
    chk("rst_instret", instret_o, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // first fetch, ack in the third REQ cycle
    push(K_REQ, 32'h0, 32'h0, 32'h0, 2'b00);
    push(K_VALID, 32'h0, 32'h0050_0093, 32'h0, 2'b00);
    en_i = 1'b1;
    fetch(32'h0050_0093, 3, 1'b0, 1'b1);
    chk("valid_after_ack", {31'h0, instr_valid_o}, 32'h1);
    chk("instr_after_ack", instr_o, 32'h0050_0093);

    // retire to pc 4, then to misaligned pc 6
    push(K_REQ, 32'h4, 32'h0, 32'h0, 2'b00);
    pulse_done(32'h4);
    chk("instret_1", instret_o, 32'h1);
    push(K_VALID, 32'h4, 32'h00a0_0113, 32'h1, 2'b00);
    fetch(32'h00a0_0113, 1, 1'b0, 1'b1);
    push(K_TRAP, 32'h6, 32'h0, 32'h0, 2'b00);
    pulse_done(32'h6);
    chk("misalign_trap", {31'h0, trap_o}, 32'h1);
    repeat (3) @(negedge clk);
    chk("misalign_no_req", {31'h0, imem_req_o}, 32'h0);

    // clear, then same-cycle ack+err
    push(K_REQ, 32'h0, 32'h0, 32'h0, 2'b00);
    push(K_TRAP, 32'h0, 32'h0, 32'h0, 2'b01);
    pulse_clr();
    chk("clr_pc", pc_o, 32'h0);
    chk("clr_trap", {31'h0, trap_o}, 32'h0);
    chk("clr_instret", instret_o, 32'h2);
    fetch(32'hdead_beef, 1, 1'b1, 1'b1);
    chk("err_trap", {30'h0, trap_o, instr_valid_o}, 32'h2);
    chk("err_instr_kept", instr_o, 32'h00a0_0113);

    // timeout: four REQ cycles then trap
    push(K_REQ, 32'h0, 32'h0, 32'h0, 2'b00);
    push(K_TRAP, 32'h0, 32'h0, 32'h0, 2'b10);
    pulse_clr();
    wait_req();
    n = 0;
    while (imem_req_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", n, 32'd4);
    chk("timeout_trap", {31'h0, trap_o}, 32'h1);

    // ack on the last allowed cycle wins over timeout
    push(K_REQ, 32'h0, 32'h0, 32'h0, 2'b00);
    push(K_VALID, 32'h0, 32'h00f0_0193, 32'h2, 2'b00);
    pulse_clr();
    fetch(32'h00f0_0193, 4, 1'b0, 1'b1);
    chk("late_ack_no_trap", {30'h0, trap_o, instr_valid_o}, 32'h1);

    // en dropped mid-fetch: fetch completes, then IDLE
    push(K_REQ, 32'h8, 32'h0, 32'h0, 2'b00);
    pulse_done(32'h8);
    push(K_VALID, 32'h8, 32'h0040_0213, 32'h3, 2'b00);
    wait_req();
    en_i = 1'b0;
    fetch(32'h0040_0213, 2, 1'b0, 1'b1);
    chk("en_drop_valid", {31'h0, instr_valid_o}, 32'h1);
    pulse_done(32'hc);
    chk("en_drop_instret", instret_o, 32'h4);
    repeat (3) @(negedge clk);
    chk("en_drop_idle", {30'h0, imem_req_o, instr_valid_o}, 32'h0);
    chk("en_drop_pc", pc_o, 32'hc);

    // async reset during REQ
    push(K_REQ, 32'hc, 32'h0, 32'h0, 2'b00);
    en_i = 1'b1;
    wait_req();
    #2 rst_n = 1'b0;
    #1 chk("async_rst_req", {31'h0, imem_req_o}, 32'h0);
    en_i = 1'b0;
    chk("async_rst_state", {instret_o[15:0], pc_o[15:0]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {31'h0, imem_req_o}, 32'h0);

    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
